// File: rtl/fifo_drain_8.sv
// fifo_drain_8 -- read-side controller for the 8-deep FIFO.
// Pops the FIFO whenever it is non-empty and there is room, and presents the
// words downstream on a valid/ready stream. A 2-entry skid buffer absorbs the
// FIFO's one-cycle read latency and downstream back-pressure.
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   en            drain enable (in-flight words still land when low)
//   fifo_empty    FIFO empty flag
//   fifo_rd_en    FIFO pop request (combinational)
//   fifo_rd_data  FIFO read data, valid the cycle after fifo_rd_en
//   out_valid     downstream valid (registered)
//   out_ready     downstream accept
//   out_data      downstream data, head of skid buffer (registered)
//   pop_cnt       16-bit count of accepted words (FIFO_DRAIN_CNT_EN only)
//
// Optional feature macro: FIFO_DRAIN_CNT_EN adds the pop_cnt port and counter.
module fifo_drain_8 #(
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef FIFO_DRAIN_CNT_EN
  ,
  output logic [15:0]       pop_cnt
`endif
);

  logic              r_inflight;
  logic [1:0]        r_occ;
  logic              r_valid;
  logic [DATA_W-1:0] r_buf0;
  logic [DATA_W-1:0] r_buf1;

  logic              w_xfer;
  logic [2:0]        w_occ_next;
  logic [1:0]        w_base;
  logic [DATA_W-1:0] w_buf0_next;
  logic [DATA_W-1:0] w_buf1_next;

  assign w_xfer = r_valid & out_ready;

  // occ + inflight - xfer at 3 bits; xfer implies occ >= 1 so never negative.
  assign w_occ_next = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_xfer};

  // Slots still holding data after this cycle's pop.
  assign w_base = r_occ - {1'b0, w_xfer};

  assign fifo_rd_en = rst_n & en & ~fifo_empty & (w_occ_next < 3'd2);

  always_comb begin
    w_buf0_next = r_buf0;
    w_buf1_next = r_buf1;
    // Only shift when buf1 holds a real word, so out_data keeps its last
    // value once the buffer empties.
    if (w_xfer && (r_occ == 2'd2)) begin
      w_buf0_next = r_buf1;
    end
    if (r_inflight) begin
      if (w_base == 2'd0) begin
        w_buf0_next = fifo_rd_data;
      end else begin
        w_buf1_next = fifo_rd_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_occ      <= '0;
      r_valid    <= 1'b0;
      r_buf0     <= '0;
      r_buf1     <= '0;
    end else begin
      r_inflight <= fifo_rd_en;
      r_occ      <= w_occ_next[1:0];
      r_valid    <= (w_occ_next != 3'd0);
      r_buf0     <= w_buf0_next;
      r_buf1     <= w_buf1_next;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_buf0;

`ifdef FIFO_DRAIN_CNT_EN
  logic [15:0] r_pop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pop_cnt <= '0;
    end else if (w_xfer) begin
      r_pop_cnt <= r_pop_cnt + 16'd1;
    end
  end

  assign pop_cnt = r_pop_cnt;
`endif

  // The issue rule must keep the buffer from overflowing.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    w_occ_next <= 3'd2);

endmodule

// File: tb/tb_fifo_drain_8.sv
module tb_fifo_drain_8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       fifo_empty = 1'b1;
  logic       fifo_rd_en;
  logic [3:0] fifo_rd_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_data;
`ifdef FIFO_DRAIN_CNT_EN
  logic [15:0] pop_cnt;
`endif

  int errors = 0;
  int checks = 0;

  fifo_drain_8 #(.DATA_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data)
`ifdef FIFO_DRAIN_CNT_EN
    ,
    .pop_cnt      (pop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: pop on a rising edge with rd_en, data valid next cycle.
  logic [3:0] fifo_q[$];
  logic [3:0] exp_q[$];
  int rd_cnt = 0;
  int rd_total = 0;
  int x_total = 0;

  always @(posedge clk) begin
    if (rst_n && fifo_rd_en) begin
      rd_cnt   = rd_cnt + 1;
      rd_total = rd_total + 1;
      if (fifo_q.size() != 0) begin
        fifo_rd_data <= fifo_q.pop_front();
      end
      fifo_empty <= (fifo_q.size() == 0);
    end
    if (rst_n && out_valid && out_ready) x_total = x_total + 1;
  end

  task automatic chk(input string name, input int act, input int expv);
    checks = checks + 1;
    if (act != expv) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic push(input logic [3:0] v);
    fifo_q.push_back(v);
    exp_q.push_back(v);
    fifo_empty = 1'b0;
  endtask

  // Monitor: scoreboard compare on every transfer plus stall-stability check.
  logic       prev_stall = 1'b0;
  logic [3:0] prev_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_data", int'(out_data), int'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", int'(out_data), -1);
        end else begin
          chk("out_data", int'(out_data), int'(exp_q.pop_front()));
        end
      end
      prev_stall = out_valid & ~out_ready;
      prev_data  = out_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for fifo_rd_en seen at a falling edge.
  task automatic wait_rd(input string name);
    int n = 0;
    @(negedge clk);
    while (!fifo_rd_en && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!fifo_rd_en) chk({name, "_rd_timeout"}, 0, 1);
  endtask

  // Count falling edges from a rd_en edge until out_valid; expected 2.
  task automatic check_latency(input string name);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, n, 2);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      step();
      n++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [3:0] bp_words[8];
    bp_words = '{4'h3, 4'h7, 4'h9, 4'hC, 4'hE, 4'h1, 4'h6, 4'hF};

    // Reset state
    repeat (3) step();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_rd_en", int'(fifo_rd_en), 0);
    rst_n = 1'b1;
    step();

    // Streaming 1..5
    out_ready = 1'b1;
    en = 1'b1;
    for (int i = 1; i <= 5; i++) push(4'(i));
    wait_rd("stream");
    check_latency("stream_latency");
    for (int i = 0; i < 5; i++) begin
      chk("stream_consecutive", int'(out_valid), 1);
      @(negedge clk);
    end
    wait_drain("stream");
`ifdef FIFO_DRAIN_CNT_EN
    chk("pop_cnt_stream", int'(pop_cnt), 5);
`endif

    // Back-pressure with 8 words
    step();
    out_ready = 1'b0;
    rd_cnt = 0;
    for (int i = 0; i < 8; i++) push(bp_words[i]);
    repeat (10) step();
    chk("bp_rd_pulses", rd_cnt, 2);
    chk("bp_valid", int'(out_valid), 1);
    chk("bp_head", int'(out_data), 3);
    out_ready = 1'b1;
    wait_drain("bp");
    chk("bp_fifo_empty", int'(fifo_empty), 1);

    // Empty boundary: single word, then a later one
    push(4'hA);
    wait_drain("emptyA");
    repeat (3) step();
    chk("empty_valid_low", int'(out_valid), 0);
    push(4'hB);
    wait_rd("emptyB");
    check_latency("emptyB_latency");
    wait_drain("emptyB");

    // Enable drop the cycle after a read
    push(4'h2);
    push(4'h4);
    push(4'h6);
    wait_rd("endrop");
    step();
    en = 1'b0;
    rd_cnt = 0;
    repeat (8) step();
    chk("endrop_no_reads", rd_cnt, 0);
    chk("endrop_inflight_delivered", exp_q.size(), 2);
    en = 1'b1;
    wait_drain("endrop");

    // Alternating ready with 6 words
    for (int i = 0; i < 6; i++) push(4'(4'h8 + 4'(i)));
    for (int i = 0; i < 30; i++) begin
      out_ready = (i % 2) == 0;
      step();
      chk("alt_occ_le2", int'((rd_total - x_total) <= 2), 1);
    end
    out_ready = 1'b1;
    wait_drain("alt");
`ifdef FIFO_DRAIN_CNT_EN
    chk("pop_cnt_total", int'(pop_cnt), 24);
`endif

    // Reset mid-stream with a full buffer
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(4'(4'h5 + 4'(i)));
    repeat (6) step();
    chk("pre_rst_valid", int'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", int'(out_valid), 0);
    chk("rst_mid_rd_en", int'(fifo_rd_en), 0);
    fifo_q.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_data", int'(out_data), 0);
    chk("post_rst_valid", int'(out_valid), 0);
`ifdef FIFO_DRAIN_CNT_EN
    chk("post_rst_pop_cnt", int'(pop_cnt), 0);
`endif
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_drain_8.md
# fifo_drain_8

Read-side controller for the 8-deep, 4-bit FIFO. It pops words from the FIFO whenever it is non-empty and presents them downstream on a valid/ready stream. A 2-entry skid buffer absorbs the FIFO's one-cycle read latency and downstream back-pressure. The block sits between the FIFO's `rd_en`/`rd_data`/`empty` pins and any consumer, such as a serializer or checker.

## Interface
- `DATA_W`, default 4: word width; must match the FIFO data width.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  drain enable; when low, no new FIFO reads are issued, but in-flight words still land.
- `fifo_empty`  in  1  FIFO empty flag, used exactly as presented.
- `fifo_rd_en`  out  1  pop request to the FIFO; combinational.
- `fifo_rd_data`  in  DATA_W  FIFO read data; valid one cycle after a cycle with `fifo_rd_en`=1.
- `out_valid`  out  1  downstream data valid; registered.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  DATA_W  downstream data = head of skid buffer; registered.
- `pop_cnt`  out  16  words accepted downstream (only with `FIFO_DRAIN_CNT_EN`).

## Operation
- State:
  - `inflight` (1 bit): a read was issued last cycle.
  - `occ` (0..2): buffered words.
  - Buffer slots `buf0` (head) and `buf1`.
- Transfer `xfer` = `out_valid & out_ready`.
- Read issue: `fifo_rd_en` = `en & ~fifo_empty & (occ + inflight - xfer < 2)`.
  - Evaluate the arithmetic at 3-bit width; the result is never negative, because `xfer` implies `occ` ≥ 1.
  - `fifo_rd_en` is forced to 0 while `rst_n` is low.
- Capture: on a cycle with `inflight`=1, `fifo_rd_data` is written to the first free slot after accounting for this cycle's `xfer`.
- Pop: on `xfer`, `buf1` shifts to `buf0`.
- Simultaneous capture and pop with `occ`=1: the new word goes into `buf0`, and `occ` stays 1.
- `occ_next` = `occ` + `inflight` - `xfer`; it never exceeds 2. The issue rule guarantees this, and overflow is a design error flagged by an assertion.
- `out_valid` = (`occ` ≠ 0). `out_data` = `buf0`.
  - `out_data` holds its value while `out_valid & ~out_ready` (stable-under-stall rule).
  - `out_data` keeps its last value when `occ` becomes 0.
- `en` deasserted mid-stream: the outstanding `inflight` word is still captured and delivered. The buffer drains normally.
- FIFO goes empty: no read is issued. The buffer drains. Reads resume the first cycle `fifo_empty`=0 and there is space.
- Order: words leave in exactly the FIFO pop order; no duplication, no loss.

## Timing
- Reset (async assert, sync release on the next edge):
  - `inflight`=0, `occ`=0, `out_valid`=0, `out_data`=0, `pop_cnt`=0, `fifo_rd_en`=0.
- Reset asserted mid-operation: the buffer contents and any in-flight word are discarded immediately. The FIFO pointer movement already done is not undone.
- Latency: a word popped on edge N (`fifo_rd_en`=1 in cycle N-1) appears on `out_data` with `out_valid`=1 after edge N+1, i.e. 2 cycles from issue to output.
- Throughput: 1 word/cycle sustained with `out_ready`=1 and the FIFO non-empty.
- Back-pressure: with `out_ready`=0, at most 2 reads are issued before `fifo_rd_en` stays low.
  - Worst case: `occ`=2, `inflight`=0.

## Configuration
- `FIFO_DRAIN_CNT_EN` defined:
  - Adds the `pop_cnt` output, a 16-bit counter incremented on every `xfer`.
  - Wraps 0xFFFF→0x0000. Reset to 0.
- Not defined: the `pop_cnt` port and counter logic are absent; all other behaviour is identical.

## Test plan
- Reset: `rst_n`=0 mid-stream with `occ`=2 -> same cycle `out_valid`=0, `fifo_rd_en`=0; after release, `out_data`=0 and `pop_cnt`=0.
- Streaming: FIFO preloaded 1,2,3,4,5; `en`=1, `out_ready`=1 -> first `out_valid` 2 cycles after the first `fifo_rd_en`; then 1..5 on consecutive cycles; `pop_cnt`=5.
- Back-pressure: preload 8 words, `out_ready`=0 -> exactly 2 `fifo_rd_en` pulses; `out_data`=first word stable. Then `out_ready`=1 -> all 8 delivered in order.
- Empty boundary: FIFO holds 1 word (0xA) -> a single pop, 0xA delivered, `out_valid` low afterwards. A later write of 0xB -> 0xB delivered 2 cycles after `fifo_rd_en`.
- Enable drop: deassert `en` the cycle after a `fifo_rd_en` -> the in-flight word is still delivered and no further reads occur. Re-enable -> draining resumes.
- Alternating ready: `out_ready` toggles 1/0 with 6 words queued -> all 6 delivered in order, no duplicates; `occ` never exceeds 2.
